// File: rtl/vec_lane_sequencer.sv
// Vector lane sequencer: slices a registered vector instruction into 4-lane beats
// for the exec pipes, with masked tail lanes, scalar pass-through, stall and flush.
module vec_lane_sequencer #(
  parameter int unsigned LANES = 4,
  parameter int unsigned ELEMS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_is_vector,
  input  logic [4:0]             in_len,
  input  logic [15:0]            in_tag,
  input  logic [ELEMS*16-1:0]    in_a,
  input  logic [ELEMS*16-1:0]    in_b,
  input  logic [15:0]            in_sa,
  input  logic [15:0]            in_sb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*16-1:0]    out_a,
  output logic [LANES*16-1:0]    out_b,
  output logic [LANES-1:0]       out_mask,
  output logic [1:0]             out_beat,
  output logic                   out_last,
  output logic [15:0]            out_tag,
  output logic                   out_is_vector
);

  localparam int unsigned BW = LANES * 16;
  localparam int unsigned VW = ELEMS * 16;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_valid, w_valid_nxt;
  logic [BW-1:0]    r_out_a, w_out_a_nxt;
  logic [BW-1:0]    r_out_b, w_out_b_nxt;
  logic [LANES-1:0] r_mask, w_mask_nxt;
  logic [1:0]       r_beat, w_beat_nxt;
  logic             r_last, w_last_nxt;
  logic [15:0]      r_tag, w_tag_nxt;
  logic             r_vec, w_vec_nxt;
  logic [VW-1:0]    r_op_a, w_op_a_nxt;
  logic [VW-1:0]    r_op_b, w_op_b_nxt;
  logic [4:0]       r_len, w_len_nxt;
  logic [1:0]       r_lastb, w_lastb_nxt;

  logic             w_accept;
  logic [4:0]       w_len_eff;
  logic [1:0]       w_lastb_in;
  logic [1:0]       w_beat_inc;

  function automatic logic [BW-1:0] f_slice(input logic [VW-1:0] v, input logic [1:0] k);
    return BW'(v >> (32'(k) * BW));
  endfunction

  function automatic logic [LANES-1:0] f_mask(input logic [1:0] k, input logic [4:0] len);
    logic [LANES-1:0] m;
    m = '0;
    for (int unsigned j = 0; j < LANES; j++)
      m[j] = ((32'(k) * LANES + j) < 32'(len));
    return m;
  endfunction

  function automatic logic [1:0] f_lastb(input logic [4:0] len);
    return (len == 5'd0) ? 2'd0 : 2'((32'(len) - 1) / LANES);
  endfunction

  assign in_ready   = !rst && !flush &&
                      ((r_state == IDLE) || (r_state == ISSUE && out_ready && r_last));
  assign w_accept   = in_valid && in_ready;
  assign w_len_eff  = (in_len > 5'(ELEMS)) ? 5'(ELEMS) : in_len;
  assign w_lastb_in = f_lastb(w_len_eff);
  assign w_beat_inc = r_beat + 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_out_a_nxt = r_out_a;
    w_out_b_nxt = r_out_b;
    w_mask_nxt  = r_mask;
    w_beat_nxt  = r_beat;
    w_last_nxt  = r_last;
    w_tag_nxt   = r_tag;
    w_vec_nxt   = r_vec;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_len_nxt   = r_len;
    w_lastb_nxt = r_lastb;
    if (flush) begin
      w_state_nxt = IDLE;
      w_valid_nxt = 1'b0;
    end else if (w_accept) begin
      // Beat 0 is built straight from the inputs so it is visible one cycle after accept.
      w_state_nxt = ISSUE;
      w_valid_nxt = 1'b1;
      w_beat_nxt  = 2'd0;
      w_tag_nxt   = in_tag;
      w_vec_nxt   = in_is_vector;
      w_op_a_nxt  = in_a;
      w_op_b_nxt  = in_b;
      w_len_nxt   = w_len_eff;
      if (in_is_vector) begin
        w_lastb_nxt = w_lastb_in;
        w_out_a_nxt = f_slice(in_a, 2'd0);
        w_out_b_nxt = f_slice(in_b, 2'd0);
        w_mask_nxt  = f_mask(2'd0, w_len_eff);
        w_last_nxt  = (w_lastb_in == 2'd0);
      end else begin
        w_lastb_nxt = 2'd0;
        w_out_a_nxt = BW'(in_sa);
        w_out_b_nxt = BW'(in_sb);
        w_mask_nxt  = LANES'(1);
        w_last_nxt  = 1'b1;
      end
    end else if (r_state == ISSUE && out_ready) begin
      if (r_last) begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end else begin
        w_beat_nxt  = w_beat_inc;
        w_out_a_nxt = f_slice(r_op_a, w_beat_inc);
        w_out_b_nxt = f_slice(r_op_b, w_beat_inc);
        w_mask_nxt  = f_mask(w_beat_inc, r_len);
        w_last_nxt  = (w_beat_inc == r_lastb);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_out_a <= '0;
      r_out_b <= '0;
      r_mask  <= '0;
      r_beat  <= '0;
      r_last  <= 1'b0;
      r_tag   <= '0;
      r_vec   <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_len   <= '0;
      r_lastb <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_out_a <= w_out_a_nxt;
      r_out_b <= w_out_b_nxt;
      r_mask  <= w_mask_nxt;
      r_beat  <= w_beat_nxt;
      r_last  <= w_last_nxt;
      r_tag   <= w_tag_nxt;
      r_vec   <= w_vec_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_len   <= w_len_nxt;
      r_lastb <= w_lastb_nxt;
    end
  end

  assign out_valid     = r_valid;
  assign out_a         = r_out_a;
  assign out_b         = r_out_b;
  assign out_mask      = r_mask;
  assign out_beat      = r_beat;
  assign out_last      = r_last;
  assign out_tag       = r_tag;
  assign out_is_vector = r_vec;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Self-checking bench for vec_lane_sequencer: table of instructions, hand-written
// stall/flush/reset/back-to-back sequences, and a random run against a beat-queue model.
module tb_vec_lane_sequencer;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_is_vector;
  logic [4:0]    in_len;
  logic [15:0]   in_tag, in_sa, in_sb;
  logic [255:0]  in_a, in_b;
  logic          out_valid, out_ready, out_last, out_is_vector;
  logic [63:0]   out_a, out_b;
  logic [3:0]    out_mask;
  logic [1:0]    out_beat;
  logic [15:0]   out_tag;

  vec_lane_sequencer #(.LANES(4), .ELEMS(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_vector(in_is_vector),
    .in_len(in_len), .in_tag(in_tag), .in_a(in_a), .in_b(in_b),
    .in_sa(in_sa), .in_sb(in_sb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_mask(out_mask), .out_beat(out_beat),
    .out_last(out_last), .out_tag(out_tag), .out_is_vector(out_is_vector)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b;
    logic [3:0]  mask;
    logic [1:0]  beat;
    logic        last;
    logic [15:0] tag;
    logic        vec;
  } beat_t;

  typedef struct {
    logic        vec;
    logic [4:0]  len;
    logic [15:0] tag;
    logic [15:0] sa, sb;
    int          nbeats;
    logic [3:0]  lmask;
  } vec_t;

  beat_t q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] fill(input int base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v = v | (256'(16'(base + i)) << (16 * i));
    return v;
  endfunction

  // Expands the currently offered instruction into its full list of expected beats.
  function automatic void push_instr();
    beat_t        bt;
    logic [255:0] ta, tb;
    int           le, nb, e;
    if (!in_is_vector) begin
      bt.a = 64'(in_sa); bt.b = 64'(in_sb); bt.mask = 4'b0001; bt.beat = 2'd0;
      bt.last = 1'b1; bt.tag = in_tag; bt.vec = 1'b0;
      q.push_back(bt);
      return;
    end
    le = (int'(in_len) > 16) ? 16 : int'(in_len);
    nb = (le == 0) ? 1 : (le + 3) / 4;
    for (int k = 0; k < nb; k++) begin
      bt.a = '0; bt.b = '0; bt.mask = '0;
      for (int j = 0; j < 4; j++) begin
        e  = 4 * k + j;
        ta = in_a >> (16 * e);
        tb = in_b >> (16 * e);
        bt.a = bt.a | (64'(ta[15:0]) << (16 * j));
        bt.b = bt.b | (64'(tb[15:0]) << (16 * j));
        if (e < le) bt.mask = bt.mask | (4'd1 << j);
      end
      bt.beat = 2'(k); bt.last = (k == nb - 1); bt.tag = in_tag; bt.vec = 1'b1;
      q.push_back(bt);
    end
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    logic exp_rdy, acc, did_rst;
    #1;
    exp_rdy = !rst && !flush && (q.size() == 0 || (out_ready && q[0].last));
    chk("in_ready", in_ready, exp_rdy);
    acc     = in_valid && exp_rdy;
    did_rst = rst;
    @(posedge clk);
    if (rst || flush) q.delete();
    else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (acc) push_instr();
    end
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    if (did_rst) begin
      chk("rst_a", out_a, 0); chk("rst_b", out_b, 0); chk("rst_tag", out_tag, 0);
      chk("rst_mask", out_mask, 0); chk("rst_beat", out_beat, 0);
      chk("rst_last", out_last, 0); chk("rst_vec", out_is_vector, 0);
    end else if (q.size() != 0) begin
      chk("out_a", out_a, q[0].a); chk("out_b", out_b, q[0].b);
      chk("out_mask", out_mask, q[0].mask); chk("out_beat", out_beat, q[0].beat);
      chk("out_last", out_last, q[0].last); chk("out_tag", out_tag, q[0].tag);
      chk("out_is_vector", out_is_vector, q[0].vec);
    end
    @(negedge clk);
  endtask

  task automatic set_vec(input logic [4:0] len, input logic [15:0] tag, input int base);
    in_is_vector = 1'b1; in_len = len; in_tag = tag;
    in_a = fill(base); in_b = fill(base + 16'h80); in_valid = 1'b1;
  endtask

  vec_t tbl[8];
  int   cnt;
  logic [3:0] lm;

  initial begin
    tbl[0] = '{1'b0, 5'd0,  16'h0010, 16'h0005, 16'h0003, 1, 4'b0001};
    tbl[1] = '{1'b1, 5'd16, 16'h0100, 16'h0000, 16'h0000, 4, 4'b1111};
    tbl[2] = '{1'b1, 5'd6,  16'h0104, 16'h0000, 16'h0000, 2, 4'b0011};
    tbl[3] = '{1'b1, 5'd0,  16'h0108, 16'h0000, 16'h0000, 1, 4'b0000};
    tbl[4] = '{1'b1, 5'd20, 16'h010c, 16'h0000, 16'h0000, 4, 4'b1111};
    tbl[5] = '{1'b1, 5'd13, 16'h0110, 16'h0000, 16'h0000, 4, 4'b0001};
    tbl[6] = '{1'b1, 5'd4,  16'h0114, 16'h0000, 16'h0000, 1, 4'b1111};
    tbl[7] = '{1'b1, 5'd9,  16'h0118, 16'h0000, 16'h0000, 3, 4'b0001};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_is_vector = 1'b0; in_len = '0;
    in_tag = '0; in_sa = '0; in_sb = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();

    for (int t = 0; t < 8; t++) begin
      in_is_vector = tbl[t].vec; in_len = tbl[t].len; in_tag = tbl[t].tag;
      in_sa = tbl[t].sa; in_sb = tbl[t].sb; in_a = fill(0); in_b = fill(16'h80);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      cnt = 0; lm = 4'b1010;
      while (out_valid === 1'b1 && cnt < 8) begin
        cnt++;
        if (out_last) lm = out_mask;
        step();
      end
      chk("nbeats", 64'(cnt), 64'(tbl[t].nbeats));
      chk("last_mask", lm, tbl[t].lmask);
    end

    // Back-to-back: second op queued behind a len=16 op issues with no bubble.
    set_vec(5'd16, 16'h0111, 0);
    step();
    set_vec(5'd4, 16'h0222, 16'h100);
    step(); step();
    chk("b2b_beat2_a", out_a, 64'h000b_000a_0009_0008);
    step(); step();
    chk("b2b_tag", out_tag, 16'h0222);
    chk("b2b_beat", out_beat, 2'd0);
    in_valid = 1'b0;
    step();

    // Stall on beat 1 of a len=8 op.
    set_vec(5'd8, 16'h0333, 16'h20);
    step();
    in_valid = 1'b0;
    step();
    chk("stall_last", out_last, 1'b1);
    out_ready = 1'b0;
    step(); step(); step();
    out_ready = 1'b1;
    step();
    chk("stall_done", out_valid, 1'b0);

    // Flush during beat 1 with a pending offer.
    set_vec(5'd16, 16'h0444, 0);
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1; in_is_vector = 1'b0; in_tag = 16'h0555; in_sa = 16'h1234;
    in_sb = 16'h4321; in_valid = 1'b1;
    step();
    chk("flush_valid", out_valid, 1'b0);
    flush = 1'b0;
    step();
    chk("flush_pending_tag", out_tag, 16'h0555);
    in_valid = 1'b0;
    step();

    // Reset during beat 2, then normal restart.
    set_vec(5'd16, 16'h0666, 0);
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_vec(5'd16, 16'h0777, 16'h40);
    step();
    chk("rst_restart_a", out_a, 64'h0043_0042_0041_0040);
    in_valid = 1'b0;
    step(); step(); step(); step();

    for (int c = 0; c < 400; c++) begin
      rst          = ($urandom % 64) == 0;
      flush        = ($urandom % 16) == 0;
      in_valid     = ($urandom % 3) != 0;
      out_ready    = ($urandom % 4) != 0;
      in_is_vector = ($urandom % 5) != 0;
      in_len       = 5'($urandom % 32);
      in_tag       = 16'($urandom);
      in_sa        = 16'($urandom);
      in_sb        = 16'($urandom);
      in_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      in_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vec_lane_sequencer.md
VEC_LANE_SEQUENCER -- requirements
Module: vec_lane_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 4, number of exec pipes fed per beat (fixed at 4; other values unsupported).
REQ-002 SHALL have parameter ELEMS, default 16, maximum 16-bit elements per vector register (256-bit).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 flush  input  1  pipeline flush; discards the in-flight instruction.
REQ-006 in_valid  input  1  upstream (fetch-regs) instruction offered.
REQ-007 in_ready  output  1  sequencer accepts the offer this cycle.
REQ-008 in_is_vector  input  1  1 = vector op, 0 = scalar op.
REQ-009 in_len  input  5  vector element count, 0..31.
REQ-010 in_tag  input  16  instruction PC, passed through unchanged.
REQ-011 in_a, in_b  input  256 each  vector operands; element i at bits [16i+15:16i].
REQ-012 in_sa, in_sb  input  16 each  scalar operands.
REQ-013 out_valid  output  1  beat offered to the exec pipes.
REQ-014 out_ready  input  1  exec pipes accept the beat.
REQ-015 out_a, out_b  output  64 each  lane j operand at bits [16j+15:16j].
REQ-016 out_mask  output  4  per-lane valid bits.
REQ-017 out_beat  output  2  beat index within the instruction.
REQ-018 out_last  output  1  final beat of the instruction.
REQ-019 out_tag  output  16  tag of the instruction being issued; out_is_vector  output  1  op type of that instruction.

Function
REQ-020 SHALL use a two-state FSM: IDLE (out_valid=0) and ISSUE (out_valid=1).
REQ-021 Accept SHALL occur when in_valid && in_ready; operands, len, tag, and type SHALL be registered; ISSUE SHALL be entered with beat=0; the first beat SHALL appear one cycle after accept.
REQ-022 in_ready SHALL be combinational: !rst && !flush && (IDLE || (ISSUE && out_ready && out_last)), permitting back-to-back instructions with no bubble.
REQ-023 Effective length SHALL be min(in_len,16); nbeats = max(1, ceil(len_eff/4)).
REQ-024 Vector beat k SHALL drive lane j with element 4k+j of a/b; out_mask[j] = (4k+j < len_eff); masked lanes SHALL still carry the element data.
REQ-025 len_eff=0 SHALL produce one beat with out_mask=0000 and out_last=1.
REQ-026 A scalar op SHALL produce one beat: lane0=in_sa/in_sb, lanes 1-3 = 0, mask 0001, beat 0, last 1.
REQ-027 out_last SHALL be 1 iff beat == nbeats-1.
REQ-028 On out_valid && out_ready: if !out_last, beat SHALL increment; if out_last, the FSM SHALL load a simultaneous accept (beat=0) or otherwise return to IDLE.
REQ-029 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-030 flush SHALL take priority over all events: the next cycle SHALL be IDLE with out_valid=0, and no accept SHALL occur in the flush cycle.
REQ-031 All outputs other than in_ready SHALL be driven from registers.

Reset
REQ-032 When rst=1 at posedge: FSM SHALL go to IDLE; out_valid, out_mask, out_beat, out_last, out_is_vector SHALL be 0; out_a, out_b, out_tag SHALL be 0.
REQ-033 rst SHALL override flush and any in-progress instruction; that instruction SHALL be discarded, and in_ready SHALL be 0 during rst.

Verification
REQ-034 Scalar op (sa=0x0005, sb=0x0003, tag=0x0010, out_ready=1) -> next cycle: out_valid=1, out_a[15:0]=0x0005, out_b[15:0]=0x0003, mask=0001, beat=0, last=1, tag=0x0010; then IDLE.
REQ-035 Vector op, len=16, element i = i, out_ready=1 -> 4 consecutive beats with beat 0..3 and mask 1111; beat 2 out_a lanes = 8,9,10,11; last only on beat 3; in_ready=0 during beats 0-2 and 1 during beat 3; a second queued op issues its beat 0 on the following cycle.
REQ-036 Vector op, len=6 -> 2 beats with masks 1111 then 0011; len=0 -> 1 beat with mask 0000 and last=1; len=20 -> 4 beats, identical to len=16.
REQ-037 Vector op, len=8, out_ready=0 for 3 cycles during beat 1 -> outputs are held constant for all 3 cycles; beat 1 is not repeated after out_ready rises; last=1 on beat 1.
REQ-038 flush asserted during beat 1 of a len=16 op while in_valid=1 -> next cycle out_valid=0 and nothing is accepted; the cycle after, the pending op is accepted.
REQ-039 rst asserted during beat 2 -> next cycle all REQ-032 outputs = 0; after rst falls, a new op issues normally from beat 0.
